mc_control_fsm: RTL and testbench

- Multicycle ARM main controller. Sequences each instruction through fetch/decode/execute/writeback and drives all datapath selects.
- Issues unconditional write requests (RegW, MemW, FlagW, PCS). The downstream condition-check/flag stage gates these with the instruction's condition field.
- Sits between the instruction register fields (Op, Funct, Rd) and the datapath muxes and enables.

---
 rtl/mc_control_fsm_if.sv | 34 +++
 rtl/mc_control_fsm.sv | 161 ++++++++++++++++
 tb/tb_mc_control_fsm.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle main controller.
// Controller takes the master modport; the instruction register / datapath side takes slave.
interface mc_control_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [1:0] FlagW;
    logic       RegW;
    logic       MemW;
    logic       PCS;
    logic       InstrDone;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Rd,
        output IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
               ALUControl, FlagW, RegW, MemW, PCS, InstrDone, State
    );

    modport slave (
        output Op, Funct, Rd,
        input  IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
               ALUControl, FlagW, RegW, MemW, PCS, InstrDone, State
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle ARM main controller: steps each instruction through fetch/decode/execute/writeback.
// Outputs are combinational from state and instruction fields (zero latency); no backpressure, one state per clock.
module mc_control_fsm (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     r_state;

    logic       w_cmd_ok;
    logic [1:0] w_alu_dec;
    logic [1:0] w_flag_dec;

    logic       w_irwrite;
    logic       w_nextpc;
    logic       w_adrsrc;
    logic [1:0] w_resultsrc;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluctl;
    logic [1:0] w_flagw;
    logic       w_regw;
    logic       w_memw;
    logic       w_pcs;
    logic       w_done;

    // Data-processing decode; C/V flags only update for arithmetic ops.
    always_comb begin
        w_cmd_ok  = 1'b1;
        w_alu_dec = 2'b00;
        case (bus.Funct[4:1])
            4'b0100: w_alu_dec = 2'b00;
            4'b0010: w_alu_dec = 2'b01;
            4'b0000: w_alu_dec = 2'b10;
            4'b1100: w_alu_dec = 2'b11;
            default: w_cmd_ok  = 1'b0;
        endcase
        if (w_cmd_ok) begin
            w_flag_dec = {bus.Funct[0], bus.Funct[0] & ~w_alu_dec[1]};
        end else begin
            w_flag_dec = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.Op)
                        2'b00:   r_state <= bus.Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   r_state <= S_MEMADR;
                        2'b10:   r_state <= S_BRANCH;
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= bus.Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECR:  r_state <= S_ALUWB;
                S_EXECI:  r_state <= S_ALUWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_irwrite   = 1'b0;
        w_nextpc    = 1'b0;
        w_adrsrc    = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 1'b0;
        w_alusrcb   = 2'b00;
        w_aluctl    = 2'b00;
        w_flagw     = 2'b00;
        w_regw      = 1'b0;
        w_memw      = 1'b0;
        w_pcs       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwrite   = 1'b1;
                w_nextpc    = 1'b1;
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            S_DECODE: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
            end
            S_MEMADR: w_alusrcb = 2'b01;
            S_MEMRD:  w_adrsrc  = 1'b1;
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regw      = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWR: begin
                w_adrsrc = 1'b1;
                w_memw   = 1'b1;
                w_done   = 1'b1;
            end
            S_EXECR: begin
                w_aluctl = w_alu_dec;
                w_flagw  = w_flag_dec;
            end
            S_EXECI: begin
                w_alusrcb = 2'b01;
                w_aluctl  = w_alu_dec;
                w_flagw   = w_flag_dec;
            end
            S_ALUWB: begin
                // IR is still held here, so the unsupported-cmd decode can veto the write.
                w_regw = w_cmd_ok;
                w_done = 1'b1;
            end
            S_BRANCH: begin
                w_alusrcb   = 2'b01;
                w_resultsrc = 2'b10;
                w_pcs       = 1'b1;
                w_done      = 1'b1;
            end
            default: ;
        endcase
        if ((r_state == S_MEMWB || r_state == S_ALUWB) && bus.Rd == 4'd15 && w_regw) begin
            w_pcs = 1'b1;
        end
    end

    assign bus.IRWrite    = w_irwrite & ~reset;
    assign bus.NextPC     = w_nextpc & ~reset;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == 2'b01, bus.Op == 2'b10};
    assign bus.ALUControl = w_aluctl;
    assign bus.FlagW      = w_flagw & {2{~reset}};
    assign bus.RegW       = w_regw & ~reset;
    assign bus.MemW       = w_memw & ~reset;
    assign bus.PCS        = w_pcs & ~reset;
    assign bus.InstrDone  = w_done & ~reset;
    assign bus.State      = r_state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for the multicycle controller: instruction table plus reset corner sequences,
// per-cycle expected outputs queued and compared at the falling edge.
module tb_mc_control_fsm;
    logic clk = 1'b0;
    logic reset;

    mc_control_fsm_if bus_if();

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] state;
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
        logic [1:0] aluctl;
        logic [1:0] flagw;
        logic       regw;
        logic       memw;
        logic       pcs;
        logic       done;
    } exp_t;

    typedef struct packed {
        logic [1:0]      op;
        logic [5:0]      funct;
        logic [3:0]      rd;
        logic [2:0]      n;
        logic [4:0][3:0] st;
        logic [1:0]      alu;
        logic [1:0]      flagw;
        logic            wb_regw;
        logic            wb_pcs;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    vec_t vecs[11];

    function automatic vec_t mk(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                                input logic [2:0] n, input logic [3:0] s0, input logic [3:0] s1,
                                input logic [3:0] s2, input logic [3:0] s3, input logic [3:0] s4,
                                input logic [1:0] alu, input logic [1:0] flagw,
                                input logic wb_regw, input logic wb_pcs);
        vec_t v;
        v.op = op; v.funct = funct; v.rd = rd; v.n = n;
        v.st[0] = s0; v.st[1] = s1; v.st[2] = s2; v.st[3] = s3; v.st[4] = s4;
        v.alu = alu; v.flagw = flagw; v.wb_regw = wb_regw; v.wb_pcs = wb_pcs;
        return v;
    endfunction

    // Expected outputs written out per state from the state table, with the
    // instruction-specific ALU/flag/writeback values taken from the vector row.
    function automatic exp_t exp_for(input logic [3:0] st, input vec_t v);
        exp_t e;
        e = '0;
        e.state  = st;
        e.immsrc = v.op;
        e.regsrc = {v.op == 2'b01, v.op == 2'b10};
        case (st)
            4'd0: begin e.irwrite = 1; e.nextpc = 1; e.alusrca = 1; e.alusrcb = 2'b10; e.resultsrc = 2'b10; end
            4'd1: begin e.alusrca = 1; e.alusrcb = 2'b10; e.resultsrc = 2'b10; end
            4'd2: e.alusrcb = 2'b01;
            4'd3: e.adrsrc = 1;
            4'd4: begin e.resultsrc = 2'b01; e.regw = v.wb_regw; e.pcs = v.wb_pcs; e.done = 1; end
            4'd5: begin e.adrsrc = 1; e.memw = 1; e.done = 1; end
            4'd6: begin e.aluctl = v.alu; e.flagw = v.flagw; end
            4'd7: begin e.alusrcb = 2'b01; e.aluctl = v.alu; e.flagw = v.flagw; end
            4'd8: begin e.regw = v.wb_regw; e.pcs = v.wb_pcs; e.done = 1; end
            4'd9: begin e.alusrcb = 2'b01; e.resultsrc = 2'b10; e.pcs = 1; e.done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t rst_gate(input exp_t e);
        exp_t r;
        r = e;
        r.irwrite = 0; r.nextpc = 0; r.regw = 0; r.memw = 0; r.pcs = 0; r.flagw = 2'b00; r.done = 0;
        return r;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.state     = bus_if.State;
        a.irwrite   = bus_if.IRWrite;
        a.nextpc    = bus_if.NextPC;
        a.adrsrc    = bus_if.AdrSrc;
        a.resultsrc = bus_if.ResultSrc;
        a.alusrca   = bus_if.ALUSrcA;
        a.alusrcb   = bus_if.ALUSrcB;
        a.immsrc    = bus_if.ImmSrc;
        a.regsrc    = bus_if.RegSrc;
        a.aluctl    = bus_if.ALUControl;
        a.flagw     = bus_if.FlagW;
        a.regw      = bus_if.RegW;
        a.memw      = bus_if.MemW;
        a.pcs       = bus_if.PCS;
        a.done      = bus_if.InstrDone;
        return a;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        exp_t a;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, nothing to compare", tag);
        end else begin
            e = sb.pop_front();
            a = sample();
            if (a !== e) begin
                failures++;
                $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                         tag, a.state, a, e.state, e);
            end
        end
    endtask

    // Called at posedge+1; queues the expectation and compares at the next falling edge.
    task automatic expect_cycle(input exp_t e, input string tag);
        sb.push_back(e);
        @(negedge clk);
        check_out(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic load_fields(input vec_t v);
        bus_if.Op    = v.op;
        bus_if.Funct = v.funct;
        bus_if.Rd    = v.rd;
    endtask

    task automatic run_row(input vec_t v, input int idx);
        load_fields(v);
        for (int i = 0; i < int'(v.n); i++) begin
            expect_cycle(exp_for(v.st[i], v), $sformatf("row%0d_cyc%0d", idx, i));
        end
    endtask

    initial begin
        //          op     funct      rd     n  states                         alu    flagw  regw pcs
        vecs[0]  = mk(2'b00, 6'b001001, 4'd1,  4, 4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 2'b00, 2'b11, 1, 0); // ADDS R1
        vecs[1]  = mk(2'b00, 6'b111000, 4'd15, 4, 4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 2'b11, 2'b00, 1, 1); // ORR imm R15
        vecs[2]  = mk(2'b01, 6'b011001, 4'd2,  5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 2'b00, 2'b00, 1, 0); // LDR
        vecs[3]  = mk(2'b01, 6'b011000, 4'd2,  4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 2'b00, 2'b00, 0, 0); // STR
        vecs[4]  = mk(2'b10, 6'b000000, 4'd0,  3, 4'd0, 4'd1, 4'd9, 4'd0, 4'd0, 2'b00, 2'b00, 0, 0); // B
        vecs[5]  = mk(2'b11, 6'b111111, 4'd15, 2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00, 2'b00, 0, 0); // undefined
        vecs[6]  = mk(2'b00, 6'b010101, 4'd3,  4, 4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 2'b00, 2'b00, 0, 0); // unsupported cmd
        vecs[7]  = mk(2'b00, 6'b100101, 4'd4,  4, 4'd0, 4'd1, 4'd7, 4'd8, 4'd0, 2'b01, 2'b11, 1, 0); // SUBS imm
        vecs[8]  = mk(2'b00, 6'b000000, 4'd15, 4, 4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 2'b10, 2'b00, 1, 1); // AND R15
        vecs[9]  = mk(2'b01, 6'b011001, 4'd15, 5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 2'b00, 2'b00, 1, 1); // LDR R15
        vecs[10] = mk(2'b00, 6'b000001, 4'd5,  4, 4'd0, 4'd1, 4'd6, 4'd8, 4'd0, 2'b10, 2'b10, 1, 0); // ANDS

        reset = 1'b1;
        load_fields(vecs[0]);
        #1;
        expect_cycle(rst_gate(exp_for(4'd0, vecs[0])), "reset_cyc0");
        expect_cycle(rst_gate(exp_for(4'd0, vecs[0])), "reset_cyc1");
        reset = 1'b0;

        for (int r = 0; r < 11; r++) begin
            run_row(vecs[r], r);
        end

        // Reset arriving while a load sits in MEMRD must abandon it without a write.
        load_fields(vecs[2]);
        expect_cycle(exp_for(4'd0, vecs[2]), "midrst_fetch");
        expect_cycle(exp_for(4'd1, vecs[2]), "midrst_decode");
        expect_cycle(exp_for(4'd2, vecs[2]), "midrst_memadr");
        reset = 1'b1;
        expect_cycle(rst_gate(exp_for(4'd3, vecs[2])), "midrst_memrd_held");
        expect_cycle(rst_gate(exp_for(4'd0, vecs[2])), "midrst_back_to_fetch");
        reset = 1'b0;
        run_row(vecs[3], 100);

        load_fields(vecs[0]);
        expect_cycle(exp_for(4'd0, vecs[0]), "final_fetch");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
